centroid_overlay: RTL

- Consumer of the centroid tracker's result bus. Latches each finished set of up to 7 centroids.
- Applies a latched set only at a frame boundary, so a frame never shows a mix of old and new markers.
- Draws a hollow square marker around each active centroid onto the 320x180 raster pixel stream that feeds display.
- Sits between the k-means tracker and the video output path, on the same clock.

---
 rtl/centroid_overlay_if.sv | 45 ++++
 rtl/centroid_overlay.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/centroid_overlay_if.sv
// centroid_overlay_if
//   Bundles the centroid result bus, the raster pixel stream and the overlay
//   results between a producer (master) and the centroid_overlay block (slave).
//
//   centroids_x_in      7 x 9-bit centroid x coordinates, index 0..6
//   centroids_y_in      7 x 8-bit centroid y coordinates, index 0..6
//   num_balls_in        number of valid centroids (0..7)
//   centroids_valid_in  1-cycle strobe, centroid fields valid
//   new_frame_in        1-cycle strobe at frame start
//   hcount_in/vcount_in pixel coordinates
//   pixel_valid_in      pixel qualifier
//   pixel_in            RGB565 input pixel
//   pixel_out           RGB565 pixel with markers applied
//   pixel_valid_out     pixel_valid_in delayed by 2 cycles
//   hit_out             pixel_out is a marker pixel
//   hit_index_out       index of the drawn centroid (0 when no hit)
//   stale_out           markers suppressed, centroid set is stale
interface centroid_overlay_if;
    logic [6:0][8:0] centroids_x_in;
    logic [6:0][7:0] centroids_y_in;
    logic [2:0]      num_balls_in;
    logic            centroids_valid_in;
    logic            new_frame_in;
    logic [8:0]      hcount_in;
    logic [7:0]      vcount_in;
    logic            pixel_valid_in;
    logic [15:0]     pixel_in;
    logic [15:0]     pixel_out;
    logic            pixel_valid_out;
    logic            hit_out;
    logic [2:0]      hit_index_out;
    logic            stale_out;

    modport master (
        output centroids_x_in, centroids_y_in, num_balls_in, centroids_valid_in,
        output new_frame_in, hcount_in, vcount_in, pixel_valid_in, pixel_in,
        input  pixel_out, pixel_valid_out, hit_out, hit_index_out, stale_out
    );

    modport slave (
        input  centroids_x_in, centroids_y_in, num_balls_in, centroids_valid_in,
        input  new_frame_in, hcount_in, vcount_in, pixel_valid_in, pixel_in,
        output pixel_out, pixel_valid_out, hit_out, hit_index_out, stale_out
    );
endinterface

// File: rtl/centroid_overlay.sv
// centroid_overlay
//   Latches finished centroid sets from the tracker, applies them at frame
//   boundaries only, and draws a hollow square marker (outline where
//   max(|dx|,|dy|) == RADIUS) around each active centroid onto the raster
//   pixel stream. Fixed 2-cycle latency, no backpressure.
//
//   clk_in  system clock, rising edge
//   rst_in  synchronous active-low reset
//   bus     centroid_overlay_if.slave (centroid bus, pixel stream, results)
module centroid_overlay #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 180,
    parameter int RADIUS       = 4,
    parameter int STALE_FRAMES = 30
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    centroid_overlay_if.slave    bus
);

    // ------------------------------------------------------------------
    // Centroid set storage
    // ------------------------------------------------------------------
    logic [6:0][8:0] shadow_x;
    logic [6:0][7:0] shadow_y;
    logic [2:0]      shadow_n;
    logic            pending;

    logic [6:0][8:0] active_x;
    logic [6:0][7:0] active_y;
    logic [2:0]      active_n;

    logic [7:0]      stale_cnt;
    logic [7:0]      stale_cnt_nxt;
    logic            stale_q;

    // A set arriving with new_frame_in, or one waiting in the shadow, makes
    // the frame fresh; otherwise the counter ages by one, saturating.
    always_comb begin
        stale_cnt_nxt = stale_cnt;
        if (bus.new_frame_in) begin
            if (bus.centroids_valid_in || pending)
                stale_cnt_nxt = '0;
            else if (stale_cnt != '1)
                stale_cnt_nxt = stale_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            shadow_x  <= '0;
            shadow_y  <= '0;
            shadow_n  <= '0;
            pending   <= 1'b0;
            active_x  <= '0;
            active_y  <= '0;
            active_n  <= '0;
            stale_cnt <= '0;
            stale_q   <= 1'b0;
        end else begin
            if (bus.new_frame_in) begin
                // Same-cycle strobe bypasses the shadow straight into active.
                if (bus.centroids_valid_in) begin
                    active_x <= bus.centroids_x_in;
                    active_y <= bus.centroids_y_in;
                    active_n <= bus.num_balls_in;
                end else if (pending) begin
                    active_x <= shadow_x;
                    active_y <= shadow_y;
                    active_n <= shadow_n;
                end
                pending   <= 1'b0;
                stale_cnt <= stale_cnt_nxt;
                stale_q   <= (stale_cnt_nxt >= 8'(STALE_FRAMES));
            end else if (bus.centroids_valid_in) begin
                shadow_x <= bus.centroids_x_in;
                shadow_y <= bus.centroids_y_in;
                shadow_n <= bus.num_balls_in;
                pending  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: per-centroid distance magnitudes
    // ------------------------------------------------------------------
    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic [6:0][9:0] dx_c, dy_c;
    logic [6:0]      en_c;
    logic            inb_c;

    always_comb begin
        dx_c = '0;
        dy_c = '0;
        en_c = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            dx_c[i] = abs_diff({1'b0, bus.hcount_in}, {1'b0, active_x[i]});
            dy_c[i] = abs_diff({2'b00, bus.vcount_in}, {2'b00, active_y[i]});
            en_c[i] = (3'(i) < active_n);
        end
        inb_c = ({1'b0, bus.hcount_in} < 10'(WIDTH)) &&
                ({1'b0, bus.vcount_in} < 9'(HEIGHT));
    end

    logic [6:0][9:0] s1_dx, s1_dy;
    logic [6:0]      s1_en;
    logic            s1_inb;
    logic            s1_valid;
    logic [15:0]     s1_pixel;

    // The count mask travels with the distances so both come from one set.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_en    <= '0;
            s1_inb   <= 1'b0;
            s1_valid <= 1'b0;
            s1_pixel <= '0;
        end else begin
            s1_dx    <= dx_c;
            s1_dy    <= dy_c;
            s1_en    <= en_c;
            s1_inb   <= inb_c;
            s1_valid <= bus.pixel_valid_in;
            s1_pixel <= bus.pixel_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: hit detection, priority select, colour
    // ------------------------------------------------------------------
    function automatic logic [15:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hF800;
            3'd1:    return 16'h07E0;
            3'd2:    return 16'h001F;
            3'd3:    return 16'hFFE0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'h07FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    logic [6:0] hit_vec;
    logic       hit_any;
    logic [2:0] hit_idx;
    logic [9:0] dmax;

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        dmax    = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            dmax       = (s1_dx[i] > s1_dy[i]) ? s1_dx[i] : s1_dy[i];
            hit_vec[i] = s1_en[i] && s1_inb && !stale_q && (dmax == 10'(RADIUS));
        end
        hit_any = |hit_vec;
        // Scan high to low so the lowest set index is the one left standing.
        for (int unsigned i = 0; i < 7; i++) begin
            if (hit_vec[6 - i])
                hit_idx = 3'(6 - i);
        end
    end

    logic [15:0] pixel_q;
    logic        valid_q;
    logic        hit_q;
    logic [2:0]  idx_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pixel_q <= '0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= s1_valid;
            if (s1_valid) begin
                pixel_q <= hit_any ? palette(hit_idx) : s1_pixel;
                hit_q   <= hit_any;
                idx_q   <= hit_any ? hit_idx : 3'd0;
            end else begin
                pixel_q <= '0;
                hit_q   <= 1'b0;
                idx_q   <= '0;
            end
        end
    end

    assign bus.pixel_out       = pixel_q;
    assign bus.pixel_valid_out = valid_q;
    assign bus.hit_out         = hit_q;
    assign bus.hit_index_out   = idx_q;
    assign bus.stale_out       = stale_q;

endmodule
